// File: rtl/mac_skew_feeder.sv
// Diagonal skew feeder for one row of mac_unit PEs: lane i is delayed i cycles
// relative to lane 0. Empty cycles become zero bubbles, and the tile is drained with a done pulse.
module mac_skew_feeder #(
    parameter int WORD_SIZE = 8,
    parameter int LANES     = 4,
    parameter int COUNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [LANES*WORD_SIZE-1:0]     in_data,
    output logic [LANES*WORD_SIZE-1:0]     out_a,
    output logic [LANES-1:0]               out_valid,
    output logic                           busy,
    output logic                           done,
    output logic [COUNT_W-1:0]             vec_count,
    output logic [1:0]                     dbg_state
);

    // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
    // in_data/in_last are ignored otherwise. There is no backpressure on the output side.

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [COUNT_W-1:0] vec_count_q, vec_count_d;
    logic               accept;

    // Ready is held low while reset is asserted as well as during the drain.
    assign in_ready  = rst && (state_q != DRAIN);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) && (drain_cnt_q == '0);
    assign vec_count = vec_count_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vec_count_q <= vec_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        vec_count_d = vec_count_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                // Count reaches zero exactly when the last lane emits its final element.
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (state_q == IDLE) begin
                vec_count_d = COUNT_W'(1);
            end else if (vec_count_q != '1) begin
                vec_count_d = vec_count_q + COUNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WORD_SIZE-1:0] data_q [0:i];
        logic                 vld_q  [0:i];

        // Non-accepted cycles inject a zero bubble so the PE accumulator is untouched.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) begin
                    data_q[j] <= '0;
                    vld_q[j]  <= 1'b0;
                end
            end else begin
                data_q[0] <= accept ? in_data[i*WORD_SIZE +: WORD_SIZE] : '0;
                vld_q[0]  <= accept;
                for (int j = 1; j <= i; j++) begin
                    data_q[j] <= data_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign out_a[i*WORD_SIZE +: WORD_SIZE] = data_q[i];
        assign out_valid[i]                    = vld_q[i];
    end

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Bench for mac_skew_feeder: a cycle-indexed history of accepted vectors predicts every lane,
// plus tile-level bookkeeping for ready/busy/done/vec_count.
module tb_mac_skew_feeder;
    localparam int W   = 8;
    localparam int L   = 4;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int DW  = L * W;
    localparam int HN  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_last;
    logic [DW-1:0] in_data;

    logic          in_ready, busy, done;
    logic [DW-1:0] out_a;
    logic [L-1:0]  out_valid;
    logic [CW-1:0] vec_count;
    logic [1:0]    dbg_state;

    logic           s_in_ready, s_busy, s_done;
    logic [DW-1:0]  s_out_a;
    logic [L-1:0]   s_out_valid;
    logic [CWS-1:0] s_vec_count;
    logic [1:0]     s_dbg_state;

    mac_skew_feeder #(.WORD_SIZE(W), .LANES(L), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .out_a(out_a), .out_valid(out_valid),
        .busy(busy), .done(done), .vec_count(vec_count), .dbg_state(dbg_state)
    );

    mac_skew_feeder #(.WORD_SIZE(W), .LANES(L), .COUNT_W(CWS)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .in_data(in_data), .out_a(s_out_a), .out_valid(s_out_valid),
        .busy(s_busy), .done(s_done), .vec_count(s_vec_count), .dbg_state(s_dbg_state)
    );

    int            n_vec = 0;
    int            n_err = 0;
    int            t;
    logic          hist_v [0:HN-1];
    logic [DW-1:0] hist_d [0:HN-1];
    bit            tile_open, draining;
    int            last_c, tile_n;

    function automatic logic [31:0] sat_cnt(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < HN; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
        tile_open = 1'b0;
        draining  = 1'b0;
        last_c    = -100;
        tile_n    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_a"}, out_a, 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_vec_count"}, 32'(vec_count), 0);
        chk({tag, "_sat_done"}, 32'(s_done), 0);
        chk({tag, "_sat_vec_count"}, 32'(s_vec_count), 0);
    endtask

    // Lane i in cycle t shows whatever was accepted in cycle t-1-i, else a zero bubble.
    task automatic check_cycle();
        logic [DW-1:0] e_a;
        logic [L-1:0]  e_v;
        int            src;
        e_a = '0;
        e_v = '0;
        for (int i = 0; i < L; i++) begin
            src = t - 1 - i;
            if (src >= 0 && hist_v[src]) begin
                e_a[i*W +: W] = hist_d[src][i*W +: W];
                e_v[i]        = 1'b1;
            end
        end
        chk("out_a", out_a, e_a);
        chk("out_valid", 32'(out_valid), 32'(e_v));
        chk("in_ready", 32'(in_ready), 32'(!(draining && t > last_c)));
        chk("busy", 32'(busy), 32'(tile_open));
        chk("done", 32'(done), 32'(draining && t == last_c + L));
        chk("vec_count", 32'(vec_count), sat_cnt(tile_n, CW));
        chk("sat_out_a", s_out_a, e_a);
        chk("sat_done", 32'(s_done), 32'(draining && t == last_c + L));
        chk("sat_vec_count", 32'(s_vec_count), sat_cnt(tile_n, CWS));
    endtask

    task automatic step(input bit v, input bit l, input logic [DW-1:0] d);
        bit acc;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        #1;
        check_cycle();
        acc = v && !(draining && t > last_c);
        if (draining && t == last_c + L) begin
            draining  = 1'b0;
            tile_open = 1'b0;
        end
        hist_v[t] = acc;
        hist_d[t] = d;
        if (acc) begin
            if (!tile_open) begin
                tile_open = 1'b1;
                tile_n    = 1;
            end else begin
                tile_n++;
            end
            if (l) begin
                draining = 1'b1;
                last_c   = t;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        chk("reset_release_ready", 32'(in_ready), 1);

        // single-vector tile
        step(1'b1, 1'b1, 32'h0403_0201);
        idle(L + 2);
        chk("single_vec_count", 32'(vec_count), 1);

        // continuous 3-vector tile
        step(1'b1, 1'b0, 32'h1312_1110);
        step(1'b1, 1'b0, 32'h2322_2120);
        step(1'b1, 1'b1, 32'h3332_3130);
        idle(L + 3);
        chk("three_vec_count", 32'(vec_count), 3);

        // bubbles between accepts; garbage data while in_valid=0 must be ignored
        step(1'b1, 1'b0, 32'hA3A2_A1A0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 32'hB3B2_B1B0);
        idle(L + 3);

        // reset in the middle of a tile
        step(1'b1, 1'b0, 32'h1312_1110);
        step(1'b1, 1'b0, 32'h2322_2120);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'h3332_3130;
        rst      = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_hold");
        rst = 1'b1;
        model_reset();
        step(1'b1, 1'b1, 32'h0403_0201);
        idle(L + 2);
        chk("after_reset_vec_count", 32'(vec_count), 1);

        // saturation of the narrow counter, then new tiles offered during the drain
        for (int k = 0; k < 5; k++) step(1'b1, (k == 4), $urandom);
        chk("sat_hold", 32'(s_vec_count), 3);
        chk("wide_count5", 32'(vec_count), 5);
        for (int k = 0; k < 2 * L + 4; k++) step(1'b1, 1'b1, $urandom);
        idle(L + 2);

        // randomized tiles with random gaps
        for (int tile = 0; tile < 30; tile++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), $urandom);
                step(1'b1, (k == n - 1), $urandom);
            end
            for (int g = 0; g < int'($urandom_range(0, L + 2)); g++) begin
                step(1'b0, 1'($urandom), $urandom);
            end
        end
        idle(L + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
